sample_packet_reader: RTL
=========================

Name: sample_packet_reader

Overview:
Readback engine for captured traces. It walks packet memory from begin_num to end_num, wrapping at MAX_SAMPLE_NUMBER. Each packet is decoded into sample data plus transition interval and streamed to the host-side uploader over a valid/ready interface, with trigger and last-sample markers. It sits between the memory interface read port and the upload path, consuming the page-aligned begin/end/trigger sample numbers produced at capture end.

Parameters:
SAMPLE_WIDTH, 16, number of data channels in a packet
SAMPLE_PACKET_WIDTH, 32, packet width returned by memory
MAX_SAMPLE_NUMBER, 32'h00FF_FFFF, highest valid sample number; the next number after it is 0
FIFO_DEPTH, 4, response buffer depth and the maximum number of outstanding reads (power of 2, at least 2)

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  one-cycle pulse; latches begin/end/trig and starts readback (ignored unless IDLE)
abort  in  1  one-cycle pulse; cancels readback
begin_num  in  32  first sample number to read
end_num  in  32  last sample number to read (inclusive)
trig_num  in  32  sample number to flag as trigger
rd_req  out  1  read request valid
rd_addr  out  32  sample number requested
rd_ack  in  1  request accepted this cycle (valid only while rd_req=1)
rd_valid  in  1  response beat valid; responses return in request order
rd_data  in  SAMPLE_PACKET_WIDTH  packet {interval, data}
out_valid  out  1  output beat valid
out_ready  in  1  consumer ready
out_data  out  SAMPLE_WIDTH  decoded sample data
out_interval  out  SAMPLE_PACKET_WIDTH-SAMPLE_WIDTH  decoded interval
out_trig  out  1  beat belongs to trig_num
out_last  out  1  beat belongs to end_num
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the final beat is accepted

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, credit count 0.
- States:
  - IDLE: on start, latch the three numbers, set req_ptr=begin_num, go to FETCH.
  - FETCH: issue reads until end_num has been requested, then go to DRAIN.
  - DRAIN: wait until the FIFO is empty and the final beat has been accepted, then go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
  - FLUSH: entered on abort from FETCH or DRAIN.
- Credits: outstanding + fifo_count must stay at or below FIFO_DEPTH. rd_req is asserted only when this holds with room for one more.
- Request pointer:
  - rd_addr = req_ptr.
  - On rd_ack, req_ptr advances by 1; if req_ptr == MAX_SAMPLE_NUMBER it becomes 0.
  - When rd_ack coincides with req_ptr == end_num, rd_req deasserts the next cycle.
- Wrap case: begin_num > end_num is legal and wraps through MAX_SAMPLE_NUMBER. begin_num == end_num reads exactly one packet.
- Responses: each rd_valid beat pushes to the FIFO and decrements outstanding. A push and a pop in the same cycle leaves fifo_count unchanged.
- Output:
  - out_valid = FIFO not empty.
  - A beat transfers when out_valid & out_ready; FIFO output is held stable while out_ready=0.
  - out_data = rd_data[SAMPLE_WIDTH-1:0]; out_interval = the upper bits of rd_data.
- Markers: a tag pointer starts at begin_num and advances with the same wrap on each popped packet. out_trig = (tag == trig_num); out_last = (tag == end_num).
- Latency: rd_valid to out_valid is 1 cycle (registered FIFO).
- FLUSH:
  - rd_req is forced low; out_valid is forced low.
  - rd_valid beats are discarded until outstanding == 0, then the FIFO is cleared and the FSM returns to IDLE.
  - No done pulse is generated.
- Ignored inputs: abort in IDLE or DONE is ignored; start while busy is ignored.
- Reset mid-operation returns to IDLE immediately.

Optional Feature:
- Macro: SAMPLE_READER_RLE_EXPAND_EN.
- With the macro: each packet expands to interval+1 beats.
  - Every beat carries the same out_data with out_interval=0.
  - out_trig is asserted on the first beat only; out_last on the final beat only.
  - A down-counter holds the FIFO head until the count is exhausted.
- Without the macro: one beat per packet, carrying the raw interval.

Decomposition:
- Shared package: TRANSITION_COUNTER_WIDTH, the FSM state enum, and a wrap-increment function (x==MAX ? 0 : x+1) used for both req_ptr and tag.
- Sub-module: packet_fifo, a synchronous FIFO of FIFO_DEPTH x SAMPLE_PACKET_WIDTH with push, pop, count and clear.

Test Plan:
- begin=4, end=7, trig=5, rd_ack always 1, 1-cycle memory latency, out_ready=1 -> addresses 4,5,6,7; 4 beats; out_trig on the 2nd beat, out_last on the 4th; done pulses once.
- MAX=15, begin=14, end=1 -> addresses 14,15,0,1; out_last on the tag=1 beat.
- out_ready held 0 for 10 cycles -> at most FIFO_DEPTH=4 requests issued; rd_req stays low until pops free credits; no data lost and order preserved.
- begin=end=9=trig, rd_data=32'h0003_ABCD -> one beat with out_data=ABCD, out_interval=3, out_trig=1, out_last=1.
- Abort in FETCH with 2 reads outstanding -> rd_req drops the next cycle; 2 late rd_valid beats are discarded; no out_valid, no done; IDLE reached; a following start works normally.
- RLE_EXPAND_EN defined, rd_data=32'h0002_0011 -> 3 beats of 0x0011, interval=0; trig/last only on the first/last beat respectively.

Source files
------------

// File: rtl/sample_packet_reader_pkg.sv
// Shared types and helpers for the sample packet readback engine.
package sample_packet_reader_pkg;

    localparam int unsigned TRANSITION_COUNTER_WIDTH = 16;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone,
        StFlush
    } state_e;

    // Sample numbers roll over to 0 after the highest valid number.
    function automatic logic [31:0] wrap_inc(input logic [31:0] x, input logic [31:0] max_num);
        return (x == max_num) ? 32'd0 : x + 32'd1;
    endfunction

endpackage

// File: rtl/sample_packet_reader_packet_fifo.sv
// Synchronous response FIFO for the sample packet reader; registered storage, clear has priority.
module sample_packet_reader_packet_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_i && !pop_i) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!push_i && pop_i) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/sample_packet_reader.sv
// Readback engine: walks packet memory begin_num..end_num (wrapping) and streams decoded samples.
// Define SAMPLE_READER_RLE_EXPAND_EN to expand each packet into interval+1 beats.
module sample_packet_reader
    import sample_packet_reader_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH        = 16,
    parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
    parameter logic [31:0] MAX_SAMPLE_NUMBER   = 32'h00FF_FFFF,
    parameter int unsigned FIFO_DEPTH          = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [31:0]                               begin_num,
    input  logic [31:0]                               end_num,
    input  logic [31:0]                               trig_num,
    output logic                                      rd_req,
    output logic [31:0]                               rd_addr,
    input  logic                                      rd_ack,
    input  logic                                      rd_valid,
    input  logic [SAMPLE_PACKET_WIDTH-1:0]            rd_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [SAMPLE_WIDTH-1:0]                   out_data,
    output logic [SAMPLE_PACKET_WIDTH-SAMPLE_WIDTH-1:0] out_interval,
    output logic                                      out_trig,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e                         state_q, state_d;
    logic [31:0]                    end_q, end_d;
    logic [31:0]                    trig_q, trig_d;
    logic [31:0]                    req_ptr_q, req_ptr_d;
    logic [31:0]                    tag_q, tag_d;
    logic [CW-1:0]                  outstanding_q, outstanding_d;
    logic [CW-1:0]                  fifo_count;
    logic                           fifo_empty, fifo_push, fifo_pop, fifo_clear;
    logic [SAMPLE_PACKET_WIDTH-1:0] head;
    logic [CW:0]                    credits_used;
    logic                           req_fire, rsp_fire, beat_fire;

`ifdef SAMPLE_READER_RLE_EXPAND_EN
    logic [TRANSITION_COUNTER_WIDTH-1:0] rle_cnt_q, rle_cnt_d, rle_left;
    logic                                rle_first_q, rle_first_d;
`endif

    sample_packet_reader_packet_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(SAMPLE_PACKET_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (fifo_clear),
        .push_i     (fifo_push),
        .push_data_i(rd_data),
        .pop_i      (fifo_pop),
        .pop_data_o (head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        // Buffered plus in-flight packets may never exceed the FIFO capacity.
        credits_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
        rd_req       = (state_q == StFetch) && (credits_used < (CW+1)'(FIFO_DEPTH));
        rd_addr      = req_ptr_q;
        req_fire     = rd_req && rd_ack;
        rsp_fire     = rd_valid && (outstanding_q != '0);
        fifo_push    = rsp_fire && ((state_q == StFetch) || (state_q == StDrain));
        out_valid    = !fifo_empty && (state_q != StFlush);
        beat_fire    = out_valid && out_ready;
        busy         = (state_q != StIdle);
        done         = (state_q == StDone);
        out_data     = head[SAMPLE_WIDTH-1:0];
`ifdef SAMPLE_READER_RLE_EXPAND_EN
        rle_left     = rle_first_q ? TRANSITION_COUNTER_WIDTH'(head[SAMPLE_PACKET_WIDTH-1:SAMPLE_WIDTH])
                                   : rle_cnt_q;
        fifo_pop     = beat_fire && (rle_left == '0);
        out_interval = '0;
        out_trig     = out_valid && rle_first_q && (tag_q == trig_q);
        out_last     = out_valid && (rle_left == '0) && (tag_q == end_q);
`else
        fifo_pop     = beat_fire;
        out_interval = head[SAMPLE_PACKET_WIDTH-1:SAMPLE_WIDTH];
        out_trig     = out_valid && (tag_q == trig_q);
        out_last     = out_valid && (tag_q == end_q);
`endif
    end

    always_comb begin
        state_d       = state_q;
        end_d         = end_q;
        trig_d        = trig_q;
        req_ptr_d     = req_ptr_q;
        tag_d         = tag_q;
        outstanding_d = outstanding_q;
        fifo_clear    = 1'b0;

        if (req_fire && !rsp_fire) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!req_fire && rsp_fire) begin
            outstanding_d = outstanding_q - CW'(1);
        end
        if (req_fire) begin
            req_ptr_d = wrap_inc(req_ptr_q, MAX_SAMPLE_NUMBER);
        end
        if (fifo_pop) begin
            tag_d = wrap_inc(tag_q, MAX_SAMPLE_NUMBER);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    end_d     = end_num;
                    trig_d    = trig_num;
                    req_ptr_d = begin_num;
                    tag_d     = begin_num;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                if (abort) begin
                    state_d = StFlush;
                end else if (req_fire && (req_ptr_q == end_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StFlush;
                end else if ((outstanding_q == '0) && fifo_empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StFlush: begin
                // Late responses are dropped; only clear once nothing is in flight.
                if (outstanding_q == '0) begin
                    fifo_clear = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            end_q         <= '0;
            trig_q        <= '0;
            req_ptr_q     <= '0;
            tag_q         <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            end_q         <= end_d;
            trig_q        <= trig_d;
            req_ptr_q     <= req_ptr_d;
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
        end
    end

`ifdef SAMPLE_READER_RLE_EXPAND_EN
    always_comb begin
        rle_first_d = rle_first_q;
        rle_cnt_d   = rle_cnt_q;
        if (fifo_clear) begin
            rle_first_d = 1'b1;
        end else if (beat_fire) begin
            if (rle_left == '0) begin
                rle_first_d = 1'b1;
            end else begin
                rle_first_d = 1'b0;
                rle_cnt_d   = rle_left - TRANSITION_COUNTER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rle_first_q <= 1'b1;
            rle_cnt_q   <= '0;
        end else begin
            rle_first_q <= rle_first_d;
            rle_cnt_q   <= rle_cnt_d;
        end
    end
`endif

endmodule
